// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, valid/ready on both sides.
// Outputs are registered; abort cancels the current transaction and returns the block to IDLE.
module booth_mult_seq #(
   parameter int W = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               mult_a,
   input  logic [W-1:0]               mult_b,
   input  logic                       abort,
   output logic                       busy,
   output logic [$clog2(W/2)-1:0]     step_idx,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2*W-1:0]             product
);

   localparam int STEPS = W / 2;
   localparam int SW    = $clog2(STEPS);
   localparam int PW    = 2 * W;

   localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   a_q;
   logic [W-1:0]    b_q;
   logic            b_prev_q;
   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   prod_q;
   logic [SW-1:0]   step_q;
   logic            in_ready_q;
   logic            busy_q;
   logic            out_valid_q;

   logic [2:0]      triplet;
   logic [PW-1:0]   pp_d;
   logic [PW-1:0]   acc_d;

   // a_q holds the sign-extended multiplicand pre-shifted by 2*step, and b_q is
   // shifted right each step, so the current triplet is always at the bottom.
   assign triplet = {b_q[1], b_q[0], b_prev_q};

   always_comb begin
      pp_d = '0;
      unique case (triplet)
         3'b001, 3'b010: pp_d = a_q;
         3'b011:         pp_d = a_q << 1;
         3'b100:         pp_d = -(a_q << 1);
         3'b101, 3'b110: pp_d = -a_q;
         default:        pp_d = '0;
      endcase
      acc_d = acc_q + pp_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         b_prev_q    <= 1'b0;
         acc_q       <= '0;
         prod_q      <= '0;
         step_q      <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid && !abort) begin
                  a_q        <= {{W{mult_a[W-1]}}, mult_a};
                  b_q        <= mult_b;
                  b_prev_q   <= 1'b0;
                  acc_q      <= '0;
                  step_q     <= '0;
                  state_q    <= S_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end

            S_RUN: begin
               if (abort) begin
                  acc_q      <= '0;
                  step_q     <= '0;
                  state_q    <= S_IDLE;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  acc_q    <= acc_d;
                  a_q      <= a_q << 2;
                  b_q      <= b_q >> 2;
                  b_prev_q <= b_q[1];
                  if (step_q == LAST_STEP) begin
                     prod_q      <= acc_d;
                     step_q      <= '0;
                     state_q     <= S_DONE;
                     busy_q      <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     step_q <= step_q + SW'(1);
                  end
               end
            end

            S_DONE: begin
               // abort and out_ready both leave DONE; the product register is kept either way.
               if (abort || out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end

            default: begin
               state_q     <= S_IDLE;
               step_q      <= '0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign step_idx  = step_q;
   assign product   = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: expected products queued on accept, checked on output.
module tb_booth_mult_seq;

   localparam int W  = 12;
   localparam int PW = 2 * W;
   localparam int SW = $clog2(W / 2);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  mult_a;
   logic [W-1:0]  mult_b;
   logic          abort;
   logic          busy;
   logic [SW-1:0] step_idx;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] product;

   always #5 clk = ~clk;

   booth_mult_seq #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mult_a    (mult_a),
      .mult_b    (mult_b),
      .abort     (abort),
      .busy      (busy),
      .step_idx  (step_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   int total = 0;
   int bad   = 0;
   logic [PW-1:0] sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [PW-1:0] m;
      m = $signed(a) * $signed(b);
      return m;
   endfunction

   // Called at a negedge in IDLE; returns at the negedge after the accept edge.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
      chk("accept_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      mult_a   = a;
      mult_b   = b;
      @(negedge clk);
      in_valid = 1'b0;
      mult_a   = W'($urandom);
      mult_b   = W'($urandom);
      chk("accept_busy", 64'(busy), 64'd1);
   endtask

   // Waits for out_valid right after accept, checking step_idx, latency and product.
   task automatic wait_done(input string tag);
      int lat;
      logic [PW-1:0] e;
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (lat < W / 2) chk({tag, "_step"}, 64'(step_idx), 64'(lat));
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd6);
      chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk({tag, "_prod"}, 64'(product), 64'(e));
      chk({tag, "_inrdy"}, 64'(in_ready), 64'd0);
      $display("txn %s product=%h expected=%h latency=%0d", tag, product, e, lat);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ov_low"}, 64'(out_valid), 64'd0);
      chk({tag, "_idle"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int sent, recv, cur_acc;
      logic [W-1:0] ra, rb;
      logic [PW-1:0] e;

      rst = 1'b1; in_valid = 1'b0; mult_a = '0; mult_b = '0;
      abort = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_step", 64'(step_idx), 64'd0);
      chk("rst_product", 64'(product), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of RUN.
      accept(12'd3, 12'd5);
      repeat (2) @(negedge clk);
      chk("midrun_step2", 64'(step_idx), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_in_ready", 64'(in_ready), 64'd1);
      chk("midrun_out_valid", 64'(out_valid), 64'd0);
      chk("midrun_busy", 64'(busy), 64'd0);
      chk("midrun_product", 64'(product), 64'd0);
      chk("midrun_step", 64'(step_idx), 64'd0);

      accept(12'd3, 12'd5); sb.push_back(24'h00000F);
      wait_done("p3x5"); handshake("p3x5");

      accept(12'd7, 12'hFFD); sb.push_back(24'hFFFFEB);
      wait_done("p7xm3"); handshake("p7xm3");
      accept(12'hFFF, 12'hFFF); sb.push_back(24'h000001);
      wait_done("pm1xm1"); handshake("pm1xm1");
      accept(12'h800, 12'h800); sb.push_back(24'h400000);
      wait_done("pminxmin"); handshake("pminxmin");
      accept(12'h800, 12'h7FF); sb.push_back(24'hC00800);
      wait_done("pminxmax"); handshake("pminxmax");

      // Backpressure: result must hold while out_ready is low.
      accept(12'd100, 12'd100); sb.push_back(24'h002710);
      wait_done("bp");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_product", 64'(product), 64'h002710);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      handshake("bp");

      // Abort during RUN.
      accept(12'd1234, 12'hDC9);
      repeat (4) @(negedge clk);
      chk("abort_step4", 64'(step_idx), 64'd4);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk("abort_no_ov", 64'(out_valid), 64'd0);
         @(negedge clk);
      end

      // Abort in IDLE blocks acceptance.
      in_valid = 1'b1; abort = 1'b1; mult_a = 12'd7; mult_b = 12'd9;
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", 64'(busy), 64'd0);
      chk("idle_abort_ready", 64'(in_ready), 64'd1);

      // Abort in DONE drops the result without a handshake.
      accept(12'd7, 12'd9); sb.push_back(24'd63);
      wait_done("done_abort");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("done_abort_ov", 64'(out_valid), 64'd0);
      chk("done_abort_ready", 64'(in_ready), 64'd1);
      $display("txn done_abort dropped");

      // Streaming with both handshakes held high.
      sent = 0; recv = 0; cur_acc = -1;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int n = 0; n < 700 && recv < 50; n++) begin
         if (out_valid) begin
            chk("stream_sb", 64'(sb.size() > 0), 64'd1);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            chk("stream_prod", 64'(product), 64'(e));
            $display("txn stream %0d product=%h expected=%h", recv, product, e);
            recv++;
         end
         if (busy) chk("stream_step", 64'(step_idx), 64'(n - cur_acc - 1));
         if (in_ready) begin
            if (sent < 50) begin
               ra = W'($urandom); rb = W'($urandom);
               mult_a = ra; mult_b = rb;
               sb.push_back(model(ra, rb));
               if (cur_acc >= 0) chk("stream_gap", 64'(n - cur_acc), 64'd8);
               cur_acc = n;
               sent++;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("stream_count", 64'(recv), 64'd50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential radix-4 Booth multiplier controller for the FFT_3 butterfly datapath.
- Accepts one signed W×W operand pair per transaction. It walks the multiplier's Booth triplets one per clock, selects the partial-product multiple {0, ±A, ±2A}, and shifts and accumulates it into a 2W-bit product.
- Provides a valid/ready handshake on input and output, so the twiddle-multiply stage can stall it.

Parameters:
- W, 12, operand width in bits. Must be even and at least 4.
- Derived: STEPS = W/2, which is the Booth step count.
- Derived: product width = 2W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- mult_a  in  W  signed multiplicand.
- mult_b  in  W  signed multiplier, which is Booth-recoded.
- abort  in  1  synchronous cancel of the current transaction.
- busy  out  1  high while in RUN.
- step_idx  out  ceil(log2(STEPS))  current Booth step, 0..STEPS-1. Value is 0 outside RUN.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  2W  signed product mult_a*mult_b.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - in_ready=1, busy=0, out_valid=0, step_idx=0, product=0.
  - All internal registers (A, B, accumulator) are cleared.
  - Reset overrides abort and handshakes, including mid-RUN.
- FSM states: IDLE, RUN, DONE.
- in_ready is 1 only in IDLE. busy is 1 only in RUN. out_valid is 1 only in DONE.
- IDLE:
  - On in_valid && in_ready, latch A=mult_a and B=mult_b.
  - Clear the accumulator, set step=0, go to RUN.
  - Inputs are ignored otherwise.
- RUN, step i:
  - Triplet t = {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0.
  - Multiple selected by t:
    - 000 and 111 → 0
    - 001 and 010 → +A
    - 011 → +2A
    - 100 → −2A
    - 101 and 110 → −A
  - Sign-extend A to 2W bits before doubling or negating. This makes A = −2^(W−1) exact, with no overflow.
  - Accumulator += multiple << 2i, computed modulo 2^(2W).
  - step increments each clock.
  - On the edge that completes step STEPS−1:
    - product ← final accumulator value, which includes the last term.
    - State goes to DONE.
- Latency:
  - Accept edge is E0.
  - Steps execute at E1..E_STEPS.
  - out_valid is first high after edge E_STEPS: 6 clocks after accept for W=12.
- DONE:
  - product and out_valid are held stable until out_ready=1.
  - On out_valid && out_ready, go to IDLE. out_valid→0; product holds its last value.
  - Back-to-back throughput is one transaction per STEPS+2 clocks. The mandatory IDLE cycle means no accept occurs in the same cycle as output.
- abort:
  - In RUN: go to IDLE at the next edge, with no out_valid and the accumulator cleared.
  - In DONE: drop out_valid and go to IDLE; the product is discarded.
  - In IDLE: no effect, and abort blocks acceptance in that cycle.
  - abort takes priority over both in_valid and out_ready.
- Operand changes on mult_a/mult_b after acceptance have no effect.
- out_ready outside DONE is ignored.

Test Plan:
- Reset mid-RUN:
  - Stimulus: accept 3×5, assert rst at step 2.
  - Required: next cycle IDLE, in_ready=1, out_valid=0, product=0.
  - Then accept 3×5 → product=24'h00000F exactly 6 clocks after accept.
- Sign and corner values:
  - 7×(−3) → 24'hFFFFEB
  - (−1)×(−1) → 24'h000001
  - 12'h800×12'h800 → 24'h400000
  - 12'h800×12'h7FF → 24'hC00800
- Backpressure:
  - Stimulus: 100×100 with out_ready=0 for 10 clocks.
  - Required: out_valid stays 1, product holds 24'h002710, in_ready stays 0.
  - Then out_ready=1 for one clock → IDLE the next cycle.
- Abort:
  - Stimulus: abort at step 4 of 1234×(−567).
  - Required: no out_valid pulse, in_ready=1 the next cycle.
  - Then abort asserted in DONE → product dropped, no handshake.
- Streaming:
  - Stimulus: in_valid and out_ready held high, 50 random signed pairs.
  - Required: every product matches the reference model.
  - Required: accept spacing is exactly 8 clocks; step_idx sequences 0..5 in each RUN.
